elevator_scheduler: RTL and testbench

Parametrised elevator car controller for an N-story building. It latches hall and car call pulses into a pending-request vector and schedules car motion with a SCAN policy: keep the current direction while requests exist ahead, otherwise reverse. It times travel and door dwell from an external tick. It sits between the debounced button front end and the story display, and replaces the fixed 5-story car/timer pairing.

---
 rtl/elevator_scheduler_if.sv | 36 +++
 rtl/elevator_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_elevator_scheduler.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/elevator_scheduler_if.sv
// Signal bundle between the button front end / story display and the elevator car controller.
interface elevator_scheduler_if #(
   parameter int FLOORS = 5
);
   localparam int FW = (FLOORS > 1) ? $clog2(FLOORS) : 1;

   // All inputs are sampled on the rising clock edge. tick, btn_*, open and shut are
   // single-cycle pulses with no handshake. arrive is a one-cycle pulse. Every other
   // output is a level that holds until the controller changes it.
   logic              enable;
   logic              tick;
   logic [FLOORS-1:0] btn_outer;
   logic [FLOORS-1:0] btn_inner;
   logic              open;
   logic              shut;
   logic [FW-1:0]     floor;
   logic [FLOORS-1:0] story_indicator;
   logic [FLOORS-1:0] pending;
   logic              door_open;
   logic              moving;
   logic              dir_up;
   logic              arrive;
   logic [1:0]        state_dbg;

   modport master (
      output enable, tick, btn_outer, btn_inner, open, shut,
      input  floor, story_indicator, pending, door_open, moving, dir_up, arrive,
             state_dbg
   );

   modport slave (
      input  enable, tick, btn_outer, btn_inner, open, shut,
      output floor, story_indicator, pending, door_open, moving, dir_up, arrive,
             state_dbg
   );
endinterface

// File: rtl/elevator_scheduler.sv
// SCAN-policy elevator car controller. It latches calls into a pending vector and
// times travel and door dwell from an external tick.
module elevator_scheduler #(
   parameter int FLOORS       = 5,
   parameter int TRAVEL_TICKS = 2,
   parameter int DOOR_TICKS   = 3
) (
   input  logic                clk,
   input  logic                resetn,
   elevator_scheduler_if.slave bus
);
   localparam int FW = (FLOORS > 1) ? $clog2(FLOORS) : 1;
   localparam int TW = (TRAVEL_TICKS > 1) ? $clog2(TRAVEL_TICKS) : 1;
   localparam int DW = (DOOR_TICKS > 1) ? $clog2(DOOR_TICKS) : 1;

   localparam logic [FW-1:0]     TOP_FLOOR   = FW'(FLOORS - 1);
   localparam logic [TW-1:0]     TRAVEL_LAST = TW'(TRAVEL_TICKS - 1);
   localparam logic [DW-1:0]     DOOR_LAST   = DW'(DOOR_TICKS - 1);
   localparam logic [FLOORS-1:0] ONE_HOT0    = FLOORS'(1);

   if (FLOORS < 2 || FLOORS > 16) begin : g_bad_floors
      $error("elevator_scheduler: FLOORS must be in 2..16");
   end
   if (TRAVEL_TICKS < 1 || DOOR_TICKS < 1) begin : g_bad_ticks
      $error("elevator_scheduler: TRAVEL_TICKS and DOOR_TICKS must be >= 1");
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MOVE = 2'd1,
      S_DOOR = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [FW-1:0]     floor_q, floor_d;
   logic [FLOORS-1:0] story_q, story_d;
   logic [FLOORS-1:0] pending_q, pending_d;
   logic              dir_up_q, dir_up_d;
   logic              arrive_q, arrive_d;
   logic [TW-1:0]     travel_cnt_q, travel_cnt_d;
   logic [DW-1:0]     door_cnt_q, door_cnt_d;

   logic [FLOORS-1:0] calls;
   logic [FLOORS-1:0] here_q, below_q, above_q;
   logic [FW-1:0]     next_floor;
   logic [FLOORS-1:0] here_n, below_n, above_n;
   logic              req_here, req_above, req_below;
   logic              calls_here;
   logic              step_ok;
   logic              pend_at_next, ahead_next;

   // Floor masks relative to the current floor, and to the floor the car is about to reach.
   always_comb begin
      calls      = bus.btn_outer | bus.btn_inner;
      here_q     = ONE_HOT0 << floor_q;
      below_q    = here_q - ONE_HOT0;
      above_q    = ~(below_q | here_q);
      req_here   = |(pending_q & here_q);
      req_above  = |(pending_q & above_q);
      req_below  = |(pending_q & below_q);
      calls_here = |(calls & here_q);

      step_ok    = dir_up_q ? (floor_q != TOP_FLOOR) : (floor_q != '0);
      next_floor = dir_up_q ? (floor_q + 1'b1) : (floor_q - 1'b1);
      here_n     = ONE_HOT0 << next_floor;
      below_n    = here_n - ONE_HOT0;
      above_n    = ~(below_n | here_n);
      pend_at_next = |(pending_q & here_n);
      ahead_next   = dir_up_q ? |(pending_q & above_n) : |(pending_q & below_n);
   end

   always_comb begin
      state_d      = state_q;
      floor_d      = floor_q;
      dir_up_d     = dir_up_q;
      arrive_d     = 1'b0;
      travel_cnt_d = travel_cnt_q;
      door_cnt_d   = door_cnt_q;

      if (bus.enable) begin
         case (state_q)
            S_IDLE: begin
               if (req_here || bus.open) begin
                  state_d = S_DOOR;
               end else if (req_above && (dir_up_q || !req_below)) begin
                  state_d  = S_MOVE;
                  dir_up_d = 1'b1;
               end else if (req_below) begin
                  state_d  = S_MOVE;
                  dir_up_d = 1'b0;
               end
            end

            S_MOVE: begin
               if (bus.tick) begin
                  if (travel_cnt_q == TRAVEL_LAST) begin
                     travel_cnt_d = '0;
                     // step_ok only fails if pending was corrupted; park rather than overrun.
                     if (step_ok) begin
                        floor_d  = next_floor;
                        arrive_d = 1'b1;
                        if (pend_at_next) begin
                           state_d = S_DOOR;
                        end else if (!ahead_next) begin
                           state_d = S_IDLE;
                        end
                     end else begin
                        state_d = S_IDLE;
                     end
                  end else begin
                     travel_cnt_d = travel_cnt_q + 1'b1;
                  end
               end
            end

            S_DOOR: begin
               if (bus.open || calls_here) begin
                  door_cnt_d = '0;
               end else if (bus.shut) begin
                  state_d = S_IDLE;
               end else if (bus.tick) begin
                  if (door_cnt_q == DOOR_LAST) begin
                     state_d = S_IDLE;
                  end else begin
                     door_cnt_d = door_cnt_q + 1'b1;
                  end
               end
            end

            default: begin
               state_d = S_IDLE;
            end
         endcase

         if (state_d != state_q) begin
            travel_cnt_d = '0;
            door_cnt_d   = '0;
         end
      end
   end

   // Calls latch even while frozen; the floor the door is (or will be) open at never latches.
   always_comb begin
      pending_d = pending_q | calls;
      if (state_d == S_DOOR) begin
         pending_d = pending_d & ~(ONE_HOT0 << floor_d);
      end
      story_d = ONE_HOT0 << floor_d;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= S_IDLE;
         floor_q      <= '0;
         story_q      <= ONE_HOT0;
         pending_q    <= '0;
         dir_up_q     <= 1'b1;
         arrive_q     <= 1'b0;
         travel_cnt_q <= '0;
         door_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         floor_q      <= floor_d;
         story_q      <= story_d;
         pending_q    <= pending_d;
         dir_up_q     <= dir_up_d;
         arrive_q     <= arrive_d;
         travel_cnt_q <= travel_cnt_d;
         door_cnt_q   <= door_cnt_d;
      end
   end

   assign bus.floor           = floor_q;
   assign bus.story_indicator = story_q;
   assign bus.pending         = pending_q;
   assign bus.door_open       = (state_q == S_DOOR);
   assign bus.moving          = (state_q == S_MOVE);
   assign bus.dir_up          = dir_up_q;
   assign bus.arrive          = arrive_q;
   assign bus.state_dbg       = state_q;
endmodule

// File: tb/tb_elevator_scheduler.sv
// Randomised and directed bench for elevator_scheduler, checked against a countdown-based car model.
module tb_elevator_scheduler;
   localparam int F  = 5;
   localparam int TT = 2;
   localparam int DT = 3;
   localparam int W  = 4 + F + 4 + F;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   elevator_scheduler_if #(.FLOORS(F)) bus ();
   elevator_scheduler_if #(.FLOORS(8)) bus8 ();

   elevator_scheduler #(.FLOORS(F), .TRAVEL_TICKS(TT), .DOOR_TICKS(DT)) dut (
      .clk(clk), .resetn(resetn), .bus(bus)
   );
   elevator_scheduler #(.FLOORS(8), .TRAVEL_TICKS(1), .DOOR_TICKS(1)) dut8 (
      .clk(clk), .resetn(resetn), .bus(bus8)
   );

   logic [W-1:0] exp_q[$];
   logic [3:0]   exp_door_q[$];
   int checks = 0;
   int errors = 0;

   // Reference car: position, direction, request set and a countdown of ticks left.
   int         m_floor;
   bit         m_up, m_door, m_move, m_arrive;
   int         m_left;
   bit [F-1:0] m_pend;

   function automatic bit any_between(bit [F-1:0] p, int lo, int hi);
      for (int i = lo; i <= hi; i++)
         if (i >= 0 && i < F && p[i]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_reset();
      m_floor = 0; m_up = 1; m_door = 0; m_move = 0; m_arrive = 0; m_left = 0; m_pend = '0;
   endtask

   task automatic model_step(bit en, bit tk, bit [F-1:0] calls, bit op, bit sh);
      bit nd, nm;
      nd = m_door; nm = m_move; m_arrive = 0;
      if (en) begin
         if (m_door) begin
            if (op || calls[m_floor]) m_left = DT;
            else if (sh) nd = 0;
            else if (tk) begin
               m_left--;
               if (m_left == 0) nd = 0;
            end
         end else if (m_move) begin
            if (tk) begin
               m_left--;
               if (m_left == 0) begin
                  m_floor = m_up ? m_floor + 1 : m_floor - 1;
                  m_arrive = 1;
                  m_left = TT;
                  if (m_pend[m_floor]) begin
                     nm = 0; nd = 1; m_left = DT;
                  end else if (!(m_up ? any_between(m_pend, m_floor + 1, F - 1)
                                      : any_between(m_pend, 0, m_floor - 1))) begin
                     nm = 0;
                  end
               end
            end
         end else begin
            if (m_pend[m_floor] || op) begin
               nd = 1; m_left = DT;
            end else if (any_between(m_pend, m_floor + 1, F - 1) &&
                         (m_up || !any_between(m_pend, 0, m_floor - 1))) begin
               nm = 1; m_up = 1; m_left = TT;
            end else if (any_between(m_pend, 0, m_floor - 1)) begin
               nm = 1; m_up = 0; m_left = TT;
            end
         end
      end
      m_pend = m_pend | calls;
      if (nd) m_pend[m_floor] = 1'b0;
      m_door = nd; m_move = nm;
   endtask

   function automatic logic [W-1:0] model_snap();
      logic [F-1:0] st;
      st = '0;
      st[m_floor] = 1'b1;
      return {4'(m_floor), m_pend, m_door, m_move, m_up, m_arrive, st};
   endfunction

   function automatic logic [W-1:0] dut_snap();
      return {4'(bus.floor), bus.pending, bus.door_open, bus.moving, bus.dir_up, bus.arrive,
              bus.story_indicator};
   endfunction

   task automatic check(string name, int act, int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   // Driver: inputs change on the falling edge; the prediction for the next rising edge is queued.
   task automatic drive(bit rn, bit en, bit tk, logic [F-1:0] outer, logic [F-1:0] inner,
                        bit op, bit sh);
      @(negedge clk);
      resetn = rn;
      bus.enable = en; bus.tick = tk; bus.btn_outer = outer; bus.btn_inner = inner;
      bus.open = op; bus.shut = sh;
      if (rn) model_step(en, tk, outer | inner, op, sh);
      else model_reset();
      exp_q.push_back(model_snap());
   endtask

   task automatic cyc(bit en, bit tk, logic [F-1:0] outer, logic [F-1:0] inner, bit op, bit sh);
      drive(1'b1, en, tk, outer, inner, op, sh);
   endtask

   task automatic idle_cycles(int n);
      repeat (n) cyc(1, 1, '0, '0, 0, 0);
   endtask

   task automatic run_until_quiet(string name, int max);
      int n;
      n = 0;
      while ((m_move || m_door || m_pend != '0) && n < max) begin
         cyc(1, 1, '0, '0, 0, 0);
         n++;
      end
      if (n >= max) begin
         checks++; errors++;
         $display("FAIL %s timeout act=%0d cycles exp=<%0d", name, n, max);
      end
      cyc(1, 1, '0, '0, 0, 0);
      #1;
   endtask

   task automatic do_reset_mid(string tag);
      @(negedge clk);
      resetn = 1'b0;
      bus.btn_outer = '0; bus.btn_inner = '0; bus.open = 0; bus.shut = 0;
      #1;
      check({tag, "_floor"}, bus.floor, 0);
      check({tag, "_story"}, bus.story_indicator, 1);
      check({tag, "_pending"}, bus.pending, 0);
      check({tag, "_door"}, bus.door_open, 0);
      check({tag, "_moving"}, bus.moving, 0);
      check({tag, "_dir_up"}, bus.dir_up, 1);
      check({tag, "_arrive"}, bus.arrive, 0);
      model_reset();
      exp_q.push_back(model_snap());
      drive(1'b0, 1, 1, '0, '0, 0, 0);
      drive(1'b1, 1, 1, '0, '0, 0, 0);
   endtask

   // Monitor: compares every predicted cycle and the floor of each door opening.
   initial begin
      logic [W-1:0] e;
      logic [3:0]   df;
      logic         door_prev;
      door_prev = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (dut_snap() !== e) begin
               errors++;
               $display("FAIL snapshot t=%0t act=%h exp=%h", $time, dut_snap(), e);
            end
         end
         if (bus.door_open && !door_prev && exp_door_q.size() > 0) begin
            df = exp_door_q.pop_front();
            checks++;
            if (4'(bus.floor) !== df) begin
               errors++;
               $display("FAIL door_floor act=%0d exp=%0d", bus.floor, df);
            end
         end
         door_prev = bus.door_open;
      end
   end

   initial begin
      int n;
      int arrivals;
      bus.enable = 1; bus.tick = 1; bus.btn_outer = '0; bus.btn_inner = '0;
      bus.open = 0; bus.shut = 0;
      bus8.enable = 1; bus8.tick = 1; bus8.btn_outer = '0; bus8.btn_inner = '0;
      bus8.open = 0; bus8.shut = 0;
      model_reset();

      do_reset_mid("reset");
      idle_cycles(2);

      // Single car call to floor 3.
      exp_door_q.push_back(4'd3);
      cyc(1, 1, '0, 5'b01000, 0, 0);
      run_until_quiet("single_call", 60);
      check("single_floor", bus.floor, 3);
      check("single_story", bus.story_indicator, 5'b01000);
      check("single_pending", bus.pending, 0);

      // Back to floor 0, then SCAN: heading for 4, floor 0 called while passing 2.
      exp_door_q.push_back(4'd0);
      cyc(1, 1, 5'b00001, '0, 0, 0);
      run_until_quiet("return_0", 60);
      exp_door_q.push_back(4'd4);
      exp_door_q.push_back(4'd0);
      cyc(1, 1, '0, 5'b10000, 0, 0);
      n = 0;
      while (!(m_arrive && m_floor == 2) && n < 40) begin
         cyc(1, 1, '0, '0, 0, 0);
         n++;
      end
      if (n >= 40) begin checks++; errors++; $display("FAIL scan_reach2 act=%0d exp=<40", n); end
      cyc(1, 1, 5'b00001, '0, 0, 0);
      run_until_quiet("scan", 100);
      check("scan_floor", bus.floor, 0);
      check("scan_dir_down", bus.dir_up, 0);
      check("scan_pending", bus.pending, 0);

      // Door control at floor 0: reload at count 2, shut, and open+shut together.
      cyc(1, 1, '0, '0, 1, 0);
      idle_cycles(2);
      cyc(1, 1, '0, '0, 1, 0);
      idle_cycles(3);
      #1;
      check("door_extended", bus.door_open, 1);
      idle_cycles(1);
      #1;
      check("door_closed_after_dwell", bus.door_open, 0);
      cyc(1, 1, '0, '0, 1, 0);
      cyc(1, 1, '0, '0, 0, 0);
      cyc(1, 1, '0, '0, 0, 1);
      idle_cycles(1);
      #1;
      check("shut_closes", bus.door_open, 0);
      cyc(1, 1, '0, '0, 1, 0);
      cyc(1, 1, '0, '0, 0, 0);
      cyc(1, 1, '0, '0, 1, 1);
      idle_cycles(1);
      #1;
      check("open_beats_shut", bus.door_open, 1);
      run_until_quiet("door_ctl", 20);

      // Enable freeze mid-travel between floors 1 and 2.
      cyc(1, 1, '0, 5'b10000, 0, 0);
      n = 0;
      while (!(m_move && m_floor == 1 && m_left == 1) && n < 40) begin
         cyc(1, 1, '0, '0, 0, 0);
         n++;
      end
      if (n >= 40) begin checks++; errors++; $display("FAIL freeze_reach act=%0d exp=<40", n); end
      for (int i = 0; i < 10; i++) cyc(0, 1, (i == 4) ? 5'b00010 : 5'b00000, '0, 0, 0);
      cyc(1, 1, '0, '0, 0, 0);
      #1;
      check("freeze_floor", bus.floor, 1);
      check("freeze_moving", bus.moving, 1);
      check("freeze_pending1", bus.pending[1], 1);
      run_until_quiet("freeze_resume", 120);

      // Asynchronous reset while travelling.
      cyc(1, 1, '0, 5'b01000, 0, 0);
      idle_cycles(3);
      do_reset_mid("reset_move");

      // Random stimulus.
      for (int i = 0; i < 1500; i++) begin
         logic [F-1:0] o, c;
         o = '0; c = '0;
         if ($urandom_range(0, 5) == 0) o[$urandom_range(0, F - 1)] = 1'b1;
         if ($urandom_range(0, 5) == 0) c[$urandom_range(0, F - 1)] = 1'b1;
         cyc($urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1, o, c,
             $urandom_range(0, 24) == 0, $urandom_range(0, 24) == 0);
      end
      run_until_quiet("random_drain", 400);

      // Parameter sweep instance: 8 floors, one tick per floor and per dwell.
      @(negedge clk);
      bus8.btn_inner = 8'h80;
      @(negedge clk);
      bus8.btn_inner = '0;
      arrivals = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus8.arrive) arrivals++;
      end
      check("sweep_arrivals", arrivals, 7);
      check("sweep_floor", bus8.floor, 7);
      check("sweep_story", bus8.story_indicator, 8'h80);
      check("sweep_pending", bus8.pending, 0);

      @(posedge clk);
      #3;
      check("exp_q_drained", exp_q.size(), 0);
      check("door_q_drained", exp_door_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
